instr_fetch_buffer: RTL and testbench

Fetch stage directly downstream of the PC register. Each cycle it presents the current PC to instruction memory, tracks in-order responses and buffers fetched instructions with their PCs in a small queue for decode. It advances the PC register only when a fetch is accepted, and discards wrong-path work on a redirect (flush).

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_buffer.sv | 133 +++++++++++++
 tb/tb_instr_fetch_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    localparam int unsigned AddrWidthDefault  = 32;
    localparam int unsigned DataWidthDefault  = 32;
    localparam int unsigned FetchDepthDefault = 4;

    typedef struct packed {
        logic [AddrWidthDefault-1:0] addr;
        logic [DataWidthDefault-1:0] data;
        logic                        filled;
    } fetch_entry_t;

    // One extra bit beyond the index so full and empty can be told apart.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues PC to imem, tracks in-order responses, queues instructions for decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the head is waiting on it.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADD_WIDTH  = AddrWidthDefault,
    parameter int unsigned DATA_WIDTH = DataWidthDefault,
    parameter int unsigned DEPTH      = FetchDepthDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADD_WIDTH-1:0]  pc,
    input  logic                  flush,
    output logic                  pc_advance,
    output logic                  imem_req,
    output logic [ADD_WIDTH-1:0]  imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADD_WIDTH-1:0]  instr_pc,
    input  logic                  instr_ready
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned IdxW = PtrW - 1;

    typedef logic [PtrW-1:0] ptr_t;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  filled;
    } entry_t;

    localparam ptr_t PtrOne   = ptr_t'(1);
    localparam ptr_t PtrDepth = ptr_t'(DEPTH);

    ptr_t   alloc_q, alloc_d, fill_q, fill_d, read_q, read_d, discard_q, discard_d;
    entry_t entries_q [DEPTH];
    entry_t entries_d [DEPTH];

    ptr_t            used, outstanding;
    logic [IdxW-1:0] alloc_idx, fill_idx, read_idx;
    entry_t          head;
    logic            gnt_fire, resp_drop, resp_keep, bypass, pop;

    assign used        = alloc_q - read_q;
    assign outstanding = alloc_q - fill_q;
    assign alloc_idx   = alloc_q[IdxW-1:0];
    assign fill_idx    = fill_q[IdxW-1:0];
    assign read_idx    = read_q[IdxW-1:0];
    assign head        = entries_q[read_idx];

    // No same-cycle pop credit: a full buffer holds the request low for this cycle.
    assign imem_req   = rst & ~flush & (used < PtrDepth);
    assign imem_addr  = pc;
    assign gnt_fire   = imem_req & imem_gnt;
    assign pc_advance = gnt_fire;

    assign resp_drop = imem_rvalid & (discard_q != '0);
    assign resp_keep = imem_rvalid & (discard_q == '0) & ~flush;

`ifdef FETCH_BYPASS_EN
    assign bypass = ~flush & ~head.filled & (discard_q == '0) & (outstanding != '0) & imem_rvalid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = rst & (head.filled | bypass);
    assign pop         = instr_valid & instr_ready & ~flush;
    assign instr       = instr_valid ? (bypass ? imem_rdata : head.data) : '0;
    assign instr_pc    = instr_valid ? head.addr : '0;

    always_comb begin
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        read_d    = read_q;
        discard_d = discard_q;
        entries_d = entries_q;
        if (flush) begin
            alloc_d = '0;
            fill_d  = '0;
            read_d  = '0;
            // Every in-flight response, minus one arriving now, must be swallowed later.
            discard_d = discard_q + outstanding - ptr_t'(imem_rvalid);
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
        end else begin
            if (resp_drop) begin
                discard_d = discard_q - PtrOne;
            end
            if (resp_keep) begin
                entries_d[fill_idx].data   = imem_rdata;
                entries_d[fill_idx].filled = 1'b1;
                fill_d                     = fill_q + PtrOne;
            end
            // Applied after the fill so a bypassed entry is consumed without staying filled.
            if (pop) begin
                entries_d[read_idx].filled = 1'b0;
                read_d                     = read_q + PtrOne;
            end
            if (gnt_fire) begin
                entries_d[alloc_idx].addr   = pc;
                entries_d[alloc_idx].filled = 1'b0;
                alloc_d                     = alloc_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_q   <= '0;
            fill_q    <= '0;
            read_q    <= '0;
            discard_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            read_q    <= read_d;
            discard_q <= discard_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed table, flush/reset sequences, random run.
// Honours FETCH_BYPASS_EN in its reference model.
module tb_instr_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    instr_fetch_buffer #(.ADD_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    // Reference model: fetch queue in program order plus a count of responses to swallow.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    ent_t        mq[$];
    resp_t       memq[$];
    int          m_discard = 0;
    int          cyc = 0;
    int          lat_cfg = 1;
    logic [31:0] pc_m = '0;

    int n_vec = 0;
    int n_err = 0;

    logic        s_req, s_adv, s_valid;
    logic [31:0] s_instr, s_ipc;

    typedef struct {
        bit          rdy;
        bit          g;
        bit          req;
        bit          adv;
        bit          vld;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_adv", pc_advance, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ipc", instr_pc, 0);
        mq.delete();
        memq.delete();
        m_discard = 0;
        pc_m      = start_pc;
        pc        = start_pc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_req", imem_req, 0);
        rst = 1'b1;
    endtask

    // One clock: drive at posedge+1, compare at posedge+4, advance model at the edge.
    task automatic cycle(input bit fl, input bit g, input bit rdy, input logic [31:0] tgt);
        bit          rv, e_req, e_adv, e_byp, e_valid;
        logic [31:0] e_instr, e_ipc, rd;
        int          unf;
        bit          found;
        rv          = (memq.size() > 0) && (memq[0].due <= cyc);
        rd          = rv ? memq[0].data : $urandom;
        pc          = pc_m;
        flush       = fl;
        imem_gnt    = g;
        instr_ready = rdy;
        imem_rvalid = rv;
        imem_rdata  = rd;

        e_req = !fl && (mq.size() < DEPTH);
        e_adv = e_req && g;
        e_byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        e_byp = !fl && (mq.size() > 0) && !mq[0].filled && (m_discard == 0) && rv;
`endif
        e_valid = ((mq.size() > 0) && mq[0].filled) || e_byp;
        e_instr = e_valid ? (e_byp ? rd : mq[0].data) : 32'h0;
        e_ipc   = e_valid ? mq[0].addr : 32'h0;

        #3;
        s_req   = imem_req;
        s_adv   = pc_advance;
        s_valid = instr_valid;
        s_instr = instr;
        s_ipc   = instr_pc;
        chk("imem_req", s_req, e_req);
        chk("pc_advance", s_adv, e_adv);
        if (e_req) chk("imem_addr", imem_addr, pc_m);
        chk("instr_valid", s_valid, e_valid);
        chk("instr", s_instr, e_instr);
        chk("instr_pc", s_ipc, e_ipc);

        @(posedge clk);
        if (rv) memq.pop_front();
        if (fl) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_discard = m_discard + unf - int'(rv);
            mq.delete();
            pc_m = tgt;
        end else begin
            if (rv) begin
                if (m_discard > 0) begin
                    m_discard--;
                end else begin
                    found = 1'b0;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!found && !mq[i].filled) begin
                            mq[i].data   = rd;
                            mq[i].filled = 1'b1;
                            found        = 1'b1;
                        end
                    end
                end
            end
            if (e_valid && rdy) void'(mq.pop_front());
            if (e_adv) begin
                mq.push_back('{addr: pc_m, data: 32'h0, filled: 1'b0});
                memq.push_back('{data: mem_data(pc_m), due: cyc + lat_cfg});
                pc_m = pc_m + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    // Run until the first valid instruction and check which PC it carries.
    task automatic expect_first_pc(input string name, input logic [31:0] want);
        logic [31:0] first;
        bit          seen;
        seen  = 1'b0;
        first = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 32'h0);
            if (!seen && s_valid) begin
                seen  = 1'b1;
                first = s_ipc;
            end
        end
        chk(name, first, want);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 1, 1, 0, 32'h00};
        tbl[1]  = '{1, 1, 1, 1, 0, 32'h00};
        tbl[2]  = '{1, 1, 1, 1, 1, 32'h00};
        tbl[3]  = '{1, 1, 1, 1, 1, 32'h04};
        tbl[4]  = '{1, 1, 1, 1, 1, 32'h08};
        tbl[5]  = '{0, 1, 1, 1, 1, 32'h0C};
        tbl[6]  = '{0, 1, 1, 1, 1, 32'h0C};
        tbl[7]  = '{0, 1, 0, 0, 1, 32'h0C};
        tbl[8]  = '{1, 1, 0, 0, 1, 32'h0C};
        tbl[9]  = '{0, 1, 1, 1, 1, 32'h10};
        tbl[10] = '{0, 1, 0, 0, 1, 32'h10};
        tbl[11] = '{1, 0, 0, 0, 1, 32'h10};
        tbl[12] = '{1, 0, 1, 0, 1, 32'h14};
        tbl[13] = '{1, 0, 1, 0, 1, 32'h18};
        tbl[14] = '{1, 0, 1, 0, 1, 32'h1C};
        tbl[15] = '{1, 0, 1, 0, 0, 32'h00};

        do_reset(32'h0);
        lat_cfg = 1;

        // Streaming, back-pressure to full, pop-without-credit, drain.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, tbl[i].g, tbl[i].rdy, 32'h0);
`ifndef FETCH_BYPASS_EN
            chk("tbl_req", s_req, tbl[i].req);
            chk("tbl_adv", s_adv, tbl[i].adv);
            chk("tbl_valid", s_valid, tbl[i].vld);
            chk("tbl_ipc", s_ipc, tbl[i].ipc);
            chk("tbl_instr", s_instr, tbl[i].vld ? mem_data(tbl[i].ipc) : 32'h0);
`endif
        end

        // Flush with two slow responses in flight; both must be swallowed.
        drain();
        lat_cfg = 5;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h100);
        lat_cfg = 1;
        expect_first_pc("flush_first_pc", 32'h100);

        // Flush coincident with a response and one more outstanding.
        drain();
        lat_cfg = 2;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h200);
        lat_cfg = 1;
        expect_first_pc("flush_rv_first_pc", 32'h200);

        // Reset with three filled entries, then restart cleanly.
        drain();
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_valid", s_valid, 1);
        do_reset(32'h40);
        expect_first_pc("post_rst_first_pc", 32'h40);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            lat_cfg = $urandom_range(1, 4);
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, 32'($urandom_range(0, 4095)) << 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
